hazard_track_unit: RTL and testbench

- Hazard and forwarding controller for the 5-stage RV32I pipeline. Sits directly downstream of the ID-stage control decoder.
- Consumes per-instruction rs1use, rs2use, hazard_optype and register addresses from ID.
- Tracks every in-flight instruction's hazard class and destination through EX/MEM/WB in its own shift registers.
- Drives stall, flush and forwarding-mux selects. Branches and jumps resolve in ID, so forwarding targets the ID-stage operand path.

---
 rtl/core_hazard_pkg.sv | 36 +++
 rtl/hazard_slot_pipe.sv | 39 +++
 rtl/hazard_track_unit.sv | 86 ++++++++
 tb/tb_hazard_track_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_hazard_pkg.sv
// Shared types and encodings for the ID-stage hazard/forwarding controller.
package core_hazard_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned OPT_W  = 2;

  // Hazard class carried by every in-flight instruction.
  typedef enum logic [OPT_W-1:0] {
    OPT_NONE  = 2'b00,
    OPT_ALU   = 2'b01,
    OPT_LOAD  = 2'b10,
    OPT_STORE = 2'b11
  } opt_e;

  // Source select for the ID-stage operand muxes.
  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_EX      = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    opt_e      optype;
    reg_addr_t rd;
    reg_addr_t rs2;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '{optype: OPT_NONE, rd: '0, rs2: '0};

  // A slot produces a register value only for ALU results and loads; x0 never matches.
  function automatic logic slot_writes(opt_e optype, reg_addr_t rd, reg_addr_t r);
    return ((optype == OPT_ALU) || (optype == OPT_LOAD)) && (rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/hazard_slot_pipe.sv
// EX/MEM/WB shadow of in-flight instructions: hazard class, destination and store source.
module hazard_slot_pipe
  import core_hazard_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      bubble_i,
  input  slot_t     id_slot_i,
  output slot_t     ex_slot_o,
  output slot_t     mem_slot_o,
  output opt_e      wb_optype_o,
  output reg_addr_t wb_rd_o
);

  slot_t     ex_q, mem_q;
  opt_e      wb_optype_q;
  reg_addr_t wb_rd_q;

  // Pipeline past ID never freezes: every slot advances each cycle, bubble enters EX on stall.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ex_q        <= SLOT_BUBBLE;
      mem_q       <= SLOT_BUBBLE;
      wb_optype_q <= OPT_NONE;
      wb_rd_q     <= '0;
    end else begin
      wb_optype_q <= mem_q.optype;
      wb_rd_q     <= mem_q.rd;
      mem_q       <= ex_q;
      ex_q        <= bubble_i ? SLOT_BUBBLE : id_slot_i;
    end
  end

  assign ex_slot_o   = ex_q;
  assign mem_slot_o  = mem_q;
  assign wb_optype_o = wb_optype_q;
  assign wb_rd_o     = wb_rd_q;

endmodule

// File: rtl/hazard_track_unit.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline (operands resolved in ID).
module hazard_track_unit
  import core_hazard_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1_ID,
  input  logic [REG_AW-1:0] rs2_ID,
  input  logic [REG_AW-1:0] rd_ID,
  input  logic              rs1use_ID,
  input  logic              rs2use_ID,
  input  logic [OPT_W-1:0]  optype_ID,
  input  logic              branch_ID,
  output logic              PC_EN_IF,
  output logic              reg_FD_EN,
  output logic              reg_FD_flush,
  output logic              reg_DE_flush,
  output logic [1:0]        forward_ctrl_A,
  output logic [1:0]        forward_ctrl_B,
  output logic              forward_ctrl_ls
);

  slot_t     id_slot, ex_slot, mem_slot;
  opt_e      wb_optype;
  reg_addr_t wb_rd;
  logic      stall;

  assign id_slot = '{optype: opt_e'(optype_ID), rd: rd_ID, rs2: rs2_ID};

  hazard_slot_pipe u_slot_pipe (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .bubble_i    (stall),
    .id_slot_i   (id_slot),
    .ex_slot_o   (ex_slot),
    .mem_slot_o  (mem_slot),
    .wb_optype_o (wb_optype),
    .wb_rd_o     (wb_rd)
  );

  // Youngest producer wins; a load still in EX is never a source (that case stalls instead).
  function automatic logic [1:0] fwd_sel(logic use_r, reg_addr_t r, slot_t ex_s, slot_t mem_s);
    logic [1:0] sel;
    sel = FWD_RF;
    if (use_r) begin
      if ((ex_s.optype == OPT_ALU) && slot_writes(ex_s.optype, ex_s.rd, r)) begin
        sel = FWD_EX;
      end else if (slot_writes(mem_s.optype, mem_s.rd, r)) begin
        sel = (mem_s.optype == OPT_ALU) ? FWD_MEM_ALU : FWD_MEM_LD;
      end
    end
    return sel;
  endfunction

  // Load-use detection; a store's rs2 is exempt because its data is patched later in MEM.
  always_comb begin
    stall = 1'b0;
    if (rst_n && (ex_slot.optype == OPT_LOAD) && (ex_slot.rd != '0)) begin
      stall = (rs1use_ID && (ex_slot.rd == rs1_ID)) ||
              (rs2use_ID && (ex_slot.rd == rs2_ID) && (opt_e'(optype_ID) != OPT_STORE));
    end
  end

  // Enables, flushes and mux selects; everything held at pass-through while in reset.
  always_comb begin
    PC_EN_IF        = 1'b1;
    reg_FD_EN       = 1'b1;
    reg_FD_flush    = 1'b0;
    reg_DE_flush    = 1'b0;
    forward_ctrl_A  = FWD_RF;
    forward_ctrl_B  = FWD_RF;
    forward_ctrl_ls = 1'b0;
    if (rst_n) begin
      PC_EN_IF        = ~stall;
      reg_FD_EN       = ~stall;
      reg_DE_flush    = stall;
      // Branch decided on stale operands during a stall; it is re-evaluated next cycle.
      reg_FD_flush    = branch_ID && !stall;
      forward_ctrl_A  = fwd_sel(rs1use_ID, rs1_ID, ex_slot, mem_slot);
      forward_ctrl_B  = fwd_sel(rs2use_ID, rs2_ID, ex_slot, mem_slot);
      forward_ctrl_ls = (mem_slot.optype == OPT_STORE) && (wb_optype == OPT_LOAD) &&
                        (wb_rd == mem_slot.rs2) && (mem_slot.rs2 != '0);
    end
  end

endmodule

// File: tb/tb_hazard_track_unit.sv
// Self-checking bench: instruction-history model plus directed literal checks.
module tb_hazard_track_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_ID, rs2_ID, rd_ID;
  logic       rs1use_ID, rs2use_ID, branch_ID;
  logic [1:0] optype_ID;
  logic       PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush, forward_ctrl_ls;
  logic [1:0] forward_ctrl_A, forward_ctrl_B;

  int total = 0;
  int bad   = 0;

  hazard_track_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rs1_ID          (rs1_ID),
    .rs2_ID          (rs2_ID),
    .rd_ID           (rd_ID),
    .rs1use_ID       (rs1use_ID),
    .rs2use_ID       (rs2use_ID),
    .optype_ID       (optype_ID),
    .branch_ID       (branch_ID),
    .PC_EN_IF        (PC_EN_IF),
    .reg_FD_EN       (reg_FD_EN),
    .reg_FD_flush    (reg_FD_flush),
    .reg_DE_flush    (reg_DE_flush),
    .forward_ctrl_A  (forward_ctrl_A),
    .forward_ctrl_B  (forward_ctrl_B),
    .forward_ctrl_ls (forward_ctrl_ls)
  );

  always #5 clk = ~clk;

  // Instructions that entered EX, oldest first: [0]=WB, [1]=MEM, [2]=EX.
  typedef struct {
    int op;
    int rd;
    int rs2;
  } ent_t;

  ent_t hist[$];
  ent_t bub = '{op: 0, rd: 0, rs2: 0};

  function automatic bit m_writes(ent_t e, int r);
    return (e.op == 1 || e.op == 2) && e.rd == r && r != 0;
  endfunction

  function automatic bit m_stall();
    ent_t ex;
    ex = hist[2];
    if (!rst_n || ex.op != 2 || ex.rd == 0) return 0;
    return (rs1use_ID && ex.rd == int'(rs1_ID)) ||
           (rs2use_ID && ex.rd == int'(rs2_ID) && optype_ID != 2'd3);
  endfunction

  function automatic int m_fwd(bit use_r, int r);
    if (!rst_n || !use_r) return 0;
    if (hist[2].op == 1 && m_writes(hist[2], r)) return 1;
    if (m_writes(hist[1], r)) return (hist[1].op == 1) ? 2 : 3;
    return 0;
  endfunction

  function automatic int m_ls();
    if (!rst_n) return 0;
    return int'(hist[1].op == 3 && hist[0].op == 2 && hist[0].rd == hist[1].rs2 &&
                hist[1].rs2 != 0);
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input int exp);
    total++;
    if (act !== 4'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    hist = {bub, bub, bub};
  end

  // Model advances at the same edge as the DUT, using inputs held since the last edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      hist = {bub, bub, bub};
    end else begin
      if (m_stall()) hist.push_back(bub);
      else hist.push_back('{op: int'(optype_ID), rd: int'(rd_ID), rs2: int'(rs2_ID)});
      void'(hist.pop_front());
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit s;
    s = m_stall();
    chk("pc_en", {3'b0, PC_EN_IF}, int'(!s));
    chk("fd_en", {3'b0, reg_FD_EN}, int'(!s));
    chk("de_flush", {3'b0, reg_DE_flush}, int'(s));
    chk("fd_flush", {3'b0, reg_FD_flush}, int'(rst_n && branch_ID && !s));
    chk("fwd_ls", {3'b0, forward_ctrl_ls}, m_ls());
    if (!s) begin
      chk("fwd_a", {2'b0, forward_ctrl_A}, m_fwd(rs1use_ID, int'(rs1_ID)));
      chk("fwd_b", {2'b0, forward_ctrl_B}, m_fwd(rs2use_ID, int'(rs2_ID)));
    end
  end

  task automatic drive(input int r1, input int r2, input int rd, input bit u1, input bit u2,
                       input int op, input bit br);
    rs1_ID    = r1[4:0];
    rs2_ID    = r2[4:0];
    rd_ID     = rd[4:0];
    rs1use_ID = u1;
    rs2use_ID = u2;
    optype_ID = op[1:0];
    branch_ID = br;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    // Reset state with a would-be matching consumer and a branch: all pass-through.
    drive(7, 7, 0, 1, 1, 1, 1);
    chk("lit_rst_pc_en", {3'b0, PC_EN_IF}, 1);
    chk("lit_rst_fd_flush", {3'b0, reg_FD_flush}, 0);
    chk("lit_rst_fwd_a", {2'b0, forward_ctrl_A}, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Back-to-back ALU: EX forward, then MEM ALU forward.
    drive(0, 0, 5, 0, 0, 1, 0); tick();
    drive(5, 0, 6, 1, 0, 1, 0);
    chk("lit_alu_ex_a", {2'b0, forward_ctrl_A}, 1);
    chk("lit_alu_ex_pc", {3'b0, PC_EN_IF}, 1);
    tick();
    drive(5, 0, 0, 1, 0, 0, 0);
    chk("lit_alu_mem_a", {2'b0, forward_ctrl_A}, 2);
    tick();

    // Load-use on rs2: one stall, then MEM load forward.
    drive(0, 0, 7, 0, 0, 2, 0); tick();
    drive(1, 7, 8, 0, 1, 1, 0);
    chk("lit_lu_pc", {3'b0, PC_EN_IF}, 0);
    chk("lit_lu_fd_en", {3'b0, reg_FD_EN}, 0);
    chk("lit_lu_de_flush", {3'b0, reg_DE_flush}, 1);
    tick();
    drive(1, 7, 8, 0, 1, 1, 0);
    chk("lit_lu_fwd_b", {2'b0, forward_ctrl_B}, 3);
    chk("lit_lu_pc2", {3'b0, PC_EN_IF}, 1);
    tick();

    // Store after load: no stall, store data patched two cycles later.
    drive(0, 0, 9, 0, 0, 2, 0); tick();
    drive(2, 9, 0, 1, 1, 3, 0);
    chk("lit_sal_pc", {3'b0, PC_EN_IF}, 1);
    chk("lit_sal_de", {3'b0, reg_DE_flush}, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("lit_sal_ls", {3'b0, forward_ctrl_ls}, 1);
    tick();

    // x0 never forwards; EX ALU beats MEM load for the same register.
    drive(0, 0, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("lit_x0_a", {2'b0, forward_ctrl_A}, 0);
    tick();
    drive(0, 0, 3, 0, 0, 2, 0); tick();
    drive(0, 0, 3, 0, 0, 1, 0); tick();
    drive(3, 0, 0, 1, 0, 0, 0);
    chk("lit_prio_a", {2'b0, forward_ctrl_A}, 1);
    tick();

    // Branch during load-use stall: stall wins, flush on the retry.
    drive(0, 0, 4, 0, 0, 2, 0); tick();
    drive(4, 0, 0, 1, 1, 0, 1);
    chk("lit_br_stall_pc", {3'b0, PC_EN_IF}, 0);
    chk("lit_br_stall_flush", {3'b0, reg_FD_flush}, 0);
    tick();
    drive(4, 0, 0, 1, 1, 0, 1);
    chk("lit_br_flush", {3'b0, reg_FD_flush}, 1);
    chk("lit_br_fd_en", {3'b0, reg_FD_EN}, 1);
    chk("lit_br_fwd_a", {2'b0, forward_ctrl_A}, 3);
    tick();

    // Reset mid-run with a load in EX: nothing stale afterwards.
    drive(0, 0, 10, 0, 0, 2, 0); tick();
    rst_n = 1'b0;
    drive(10, 0, 0, 1, 0, 1, 0);
    chk("lit_mrst_pc", {3'b0, PC_EN_IF}, 1);
    tick();
    rst_n = 1'b1;
    drive(10, 0, 0, 1, 0, 1, 0);
    chk("lit_mrst_fwd_a", {2'b0, forward_ctrl_A}, 0);
    chk("lit_mrst_de", {3'b0, reg_DE_flush}, 0);
    tick();

    // Dense mix over a few registers to stress priorities against the model.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 31) != 0);
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
            1'($urandom_range(0, 3) == 0));
      tick();
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
